// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] COM_OFF    = 4'hF;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/decoder_7seg.sv
// Hex nibble to active-low 7-segment code {p,g,f,e,d,c,b,a}, with p off.
module decoder_7seg
  import fnd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Pure lookup of the segment pattern for one hex digit.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hD8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode FND driver with dead-time blanking
// and a once-per-frame snapshot of the displayed value.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        lz_en,
  output logic [7:0]  seg_7,
  output logic [3:0]  com,
  output logic        frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
                                                  : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
  localparam int CW = $clog2(CNT_MAX);

  scan_state_t state, state_nx;
  logic [1:0]  digit, digit_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic        load;

  logic [15:0]           snap_value;
  logic [NUM_DIGITS-1:0] snap_dp;
  logic                  snap_lz;

  // Snapshot as it will be during the next cycle; outputs are computed from
  // this so the first DRIVE(0) cycle already shows the freshly captured value.
  logic [15:0]           val_nx;
  logic [NUM_DIGITS-1:0] dp_nx;
  logic                  lz_nx;
  logic [3:0]            nibble;
  logic [7:0]            dec_seg;
  logic                  blank_dig;
  logic [7:0]            seg_nx;
  logic [3:0]            com_nx;

  // Next-state, digit and dwell-counter sequencing.
  always_comb begin
    state_nx = state;
    digit_nx = digit;
    cnt_nx   = cnt + CW'(1);
    load     = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      digit_nx = 2'd0;
      cnt_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_DRIVE;
          digit_nx = 2'd0;
          cnt_nx   = '0;
          load     = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt_nx = '0;
            if (BLANK_CYC == 0) begin
              state_nx = ST_DRIVE;
              digit_nx = digit + 2'd1;
              load     = (digit == 2'd3);
            end else begin
              state_nx = ST_BLANK;
            end
          end else begin
            state_nx = ST_DRIVE;
          end
        end
        ST_BLANK: begin
          if (cnt == CW'(BLANK_CYC - 1)) begin
            cnt_nx   = '0;
            state_nx = ST_DRIVE;
            digit_nx = digit + 2'd1;
            load     = (digit == 2'd3);
          end else begin
            state_nx = ST_BLANK;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          digit_nx = 2'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Select the snapshot and nibble for the upcoming digit, plus leading-zero blanking.
  always_comb begin
    val_nx    = load ? value : snap_value;
    dp_nx     = load ? dp_en : snap_dp;
    lz_nx     = load ? lz_en : snap_lz;
    nibble    = 4'h0;
    blank_dig = 1'b0;
    case (digit_nx)
      2'd0: begin
        nibble    = val_nx[3:0];
        blank_dig = 1'b0;
      end
      2'd1: begin
        nibble    = val_nx[7:4];
        blank_dig = lz_nx && (val_nx[15:4] == 12'd0);
      end
      2'd2: begin
        nibble    = val_nx[11:8];
        blank_dig = lz_nx && (val_nx[15:8] == 8'd0);
      end
      2'd3: begin
        nibble    = val_nx[15:12];
        blank_dig = lz_nx && (val_nx[15:12] == 4'd0);
      end
      default: begin
        nibble    = 4'h0;
        blank_dig = 1'b0;
      end
    endcase
  end

  decoder_7seg u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Output pattern for the upcoming state: dp overrides bit 7, blanked digits stay selected.
  always_comb begin
    seg_nx = SEG_OFF;
    com_nx = COM_OFF;
    if (state_nx == ST_DRIVE) begin
      seg_nx = {~dp_nx[digit_nx], (blank_dig ? SEG_BLANK : dec_seg[6:0])};
      com_nx = ~(4'b0001 << digit_nx);
    end else begin
      seg_nx = SEG_OFF;
      com_nx = COM_OFF;
    end
  end

  // Sequencer state, snapshot and registered pin outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= ST_IDLE;
      digit      <= 2'd0;
      cnt        <= '0;
      snap_value <= 16'h0000;
      snap_dp    <= 4'h0;
      snap_lz    <= 1'b0;
      seg_7      <= SEG_OFF;
      com        <= COM_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      digit      <= digit_nx;
      cnt        <= cnt_nx;
      snap_value <= val_nx;
      snap_dp    <= dp_nx;
      snap_lz    <= lz_nx;
      seg_7      <= seg_nx;
      com        <= com_nx;
      frame_tick <= load;
    end
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed driver for the 4-digit common-anode 7-segment display (FND). It sequences one shared 7-segment decoder across four digits. It inserts a dead-time blanking interval between digits to suppress ghosting and snapshots the display value once per frame so a digit never tears. It sits between the binary-to-BCD or counter logic upstream and the board's seg/com pins.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is driven (1 ms at 100 MHz); must be >= 1
BLANK_CYC, 1000, clk cycles all digits are off between digits; 0 = no blanking interval

Ports:
clk  input  1  system clock, rising edge
reset_p  input  1  asynchronous, active-high reset
en  input  1  1 = scan; 0 = display dark, scanner idle
value  input  16  four hex nibbles; value[3:0] = rightmost digit (digit 0)
dp_en  input  4  decimal point enable per digit, bit k = digit k
lz_en  input  1  1 = suppress leading zeros
seg_7  output  8  active-low segments {p,g,f,e,d,c,b,a}
com  output  4  active-low digit select; com[k] drives digit k
frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Single clock domain. reset_p is asynchronous, active-high.
- Reset, asserted at any time including mid-frame, immediately forces:
  - state=IDLE, digit=0, counter=0, snapshot=0
  - seg_7=8'hFF, com=4'hF, frame_tick=0
- States:
  - IDLE: outputs off. Leaves on the first edge with en=1, going to DRIVE for digit 0 and taking a snapshot.
  - DRIVE(k): lasts exactly SCAN_DIV cycles. com = one-hot-low for digit k (e.g. digit 2 -> 4'b1011).
    - seg_7[6:0] = decoded nibble k of the snapshot.
    - seg_7[7] = ~dp_snap[k].
    - At the end of the interval, go to BLANK(k), or directly to DRIVE(k+1 mod 4) when BLANK_CYC=0.
  - BLANK(k): lasts exactly BLANK_CYC cycles. com=4'hF, seg_7=8'hFF. Then go to DRIVE(k+1 mod 4).
- Frame length is exactly 4*(SCAN_DIV+BLANK_CYC) cycles. Scan order is 0,1,2,3,0,...
- Snapshot:
  - value, dp_en and lz_en are captured into internal registers on entry to DRIVE(0), whether from IDLE or from the wrap after digit 3.
  - frame_tick is high for the first cycle of DRIVE(0) only.
  - Input changes during a frame are not visible until the next frame.
- Leading-zero suppression, when lz_en_snap=1:
  - Digit k (k=3..1) is blank if its nibble and all higher nibbles are 0. Digit 0 is never suppressed.
  - A blank digit drives seg_7[6:0]=7'h7F; its dp still follows dp_snap[k].
  - com is still asserted for a blank digit, so timing is unchanged.
- en deasserted in any state: on the next edge, state=IDLE, counter and digit cleared, outputs off. Re-assertion restarts at DRIVE(0) with a fresh snapshot.
- Outputs seg_7, com and frame_tick are registered, with no combinational path from inputs. The outputs for a state are valid in the first cycle of that state.
- Counter width is ceil(log2(max(SCAN_DIV,BLANK_CYC,2))). The counter runs 0..N-1 and reloads to 0 at each state change. There is no free-running wrap.
- Segment code table for hex 0-F:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=D8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - These values are for the {p..a} byte with p=1.

Decomposition:
- Shared package fnd_pkg holds:
  - state encoding (IDLE, DRIVE, BLANK)
  - SEG_OFF=8'hFF, COM_OFF=4'hF
  - NUM_DIGITS=4
- Sub-module: the existing decoder_7seg (4-bit hex in, 8-bit active-low out) is instantiated once, fed by the digit-k nibble mux.
  - The controller overrides bit 7 with dp and forces 7'h7F for blanked digits.

Test Plan:
1. SCAN_DIV=4, BLANK_CYC=2, value=16'h1234, dp_en=0, lz_en=0, en=1 after reset -> com sequence per 24-cycle frame is:
   - 1110 x4 with seg 99 (4)
   - 1111 x2
   - 1101 x4 with seg B0 (3)
   - 1111 x2
   - 1011 x4 with seg A4 (2)
   - 1111 x2
   - 0111 x4 with seg F9 (1)
   - 1111 x2
   frame_tick pulses every 24 cycles.
2. value=16'h0050, lz_en=1, dp_en=4'b0010 ->
   - digit3 and digit2: seg 8'hFF
   - digit1: seg 8'h12 (5 with dp)
   - digit0: seg C0
   - with value=16'h0000: only digit0 shows C0.
3. Change value from 16'h1234 to 16'hABCD during DRIVE(2) -> digits 2 and 3 of the current frame still show 2 and 1; the next frame (after frame_tick) shows D,C,b,A.
4. BLANK_CYC=0, SCAN_DIV=1 -> com rotates 1110,1101,1011,0111 every cycle, never 1111 after start; frame_tick every 4 cycles.
5. Drop en during DRIVE(1) -> next edge com=F, seg=FF and state stays IDLE. Re-raise en -> DRIVE(0) with frame_tick on the next edge.
6. Assert reset_p asynchronously mid-DRIVE(3) between clock edges -> com=F, seg=FF and frame_tick=0 before the next edge. After release with en=1, the scan restarts at digit 0.
